pipe_stage_reg: RTL and testbench

Generic parametrised pipeline stage register for the pipelined RISC-V core. It replaces fixed-field inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) with one block that carries an opaque packed payload of configurable width. It adds a valid/ready handshake, stall back-pressure, synchronous flush and a saturating stall-cycle counter. An optional skid buffer registers `in_ready` so that back-pressure never forms a combinational path through the stage.

---
 rtl/pipe_stage_reg.sv | 185 ++++++++++++++++++
 tb/tb_pipe_stage_reg.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
//
// Generic pipeline stage register for the pipelined RISC-V core. Carries an
// opaque packed payload between stages with a valid/ready handshake, stall
// back-pressure, synchronous flush and a saturating stall-cycle counter.
//
// Build option:
//   PIPE_STAGE_SKID_EN  defined   -> skid register S present, in_ready is a
//                                    flop output, capacity 2 instructions.
//                       undefined -> no skid register, in_ready depends
//                                    combinationally on out_ready, capacity 1.
//
// Parameters:
//   DATA_W         payload width in bits
//   ZERO_ON_FLUSH  1: flush and reset zero payload registers;
//                  0: flush clears only the valid bits
//   CNT_W          stall counter width
//
// Ports:
//   clk        in   clock, rising edge
//   reset      in   asynchronous, active-high reset
//   flush      in   synchronous kill of all held instructions
//   in_valid   in   upstream presents an instruction
//   in_ready   out  stage accepts an instruction this cycle
//   in_data    in   upstream payload
//   out_valid  out  stage holds a valid instruction
//   out_ready  in   downstream accepts this cycle
//   out_data   out  held payload (registered)
//   stall_cnt  out  saturating count of out_valid && !out_ready cycles
//   stall_clr  in   synchronous clear of stall_cnt (wins over increment)
// -----------------------------------------------------------------------------
module pipe_stage_reg #(
    parameter int unsigned DATA_W        = 160,
    parameter bit          ZERO_ON_FLUSH = 1'b1,
    parameter int unsigned CNT_W         = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt,
    input  logic              stall_clr
);

    // Main register M
    logic              mv_q, mv_d;
    logic [DATA_W-1:0] md_q, md_d;

    // Stall counter
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              m_free;
    logic              xfer_in;

    // M can take a new instruction when empty or when its content leaves now.
    assign m_free  = !mv_q || out_ready;
    assign xfer_in = in_valid && in_ready;

`ifdef PIPE_STAGE_SKID_EN

    // Skid register S and registered ready
    logic              sv_q, sv_d;
    logic [DATA_W-1:0] sd_q, sd_d;
    logic              rdy_q, rdy_d;

    assign in_ready = rdy_q;

    always_comb begin
        mv_d = mv_q;
        md_d = md_q;
        sv_d = sv_q;
        sd_d = sd_q;

        if (m_free) begin
            if (sv_q) begin
                // S is older than anything on the input: drain it first.
                mv_d = 1'b1;
                md_d = sd_q;
                if (xfer_in) begin
                    sv_d = 1'b1;
                    sd_d = in_data;
                end else begin
                    sv_d = 1'b0;
                end
            end else begin
                mv_d = in_valid;
                md_d = in_data;
                sv_d = 1'b0;
            end
        end else if (xfer_in) begin
            // M blocked: park the accepted instruction in S.
            sv_d = 1'b1;
            sd_d = in_data;
        end

        // Flush wins over every same-cycle transfer; a transfer out still
        // completes since downstream sampled it this cycle.
        if (flush) begin
            mv_d = 1'b0;
            sv_d = 1'b0;
            if (ZERO_ON_FLUSH) begin
                md_d = '0;
                sd_d = '0;
            end
        end

        // Ready is simply "S will be empty next cycle", held in a flop so
        // back-pressure never forms a combinational path through the stage.
        rdy_d = !sv_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sv_q  <= 1'b0;
            sd_q  <= '0;
            rdy_q <= 1'b1;
        end else begin
            sv_q  <= sv_d;
            sd_q  <= sd_d;
            rdy_q <= rdy_d;
        end
    end

`else

    assign in_ready = m_free;

    always_comb begin
        mv_d = mv_q;
        md_d = md_q;

        if (in_ready) begin
            mv_d = in_valid;
            md_d = in_data;
        end

        if (flush) begin
            mv_d = 1'b0;
            if (ZERO_ON_FLUSH) begin
                md_d = '0;
            end
        end
    end

`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mv_q <= 1'b0;
            md_q <= '0;
        end else begin
            mv_q <= mv_d;
            md_q <= md_d;
        end
    end

    // Stall counter: clear beats increment; saturates at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (stall_clr) begin
            cnt_d = '0;
        end else if (mv_q && !out_ready && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign out_valid = mv_q;
    assign out_data  = md_q;
    assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;

    localparam int unsigned DW = 32;
    localparam int unsigned CW = 4;
`ifdef PIPE_STAGE_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif
    localparam int CAP = SKID ? 2 : 1;

    logic          clk;
    logic          reset;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [CW-1:0] stall_cnt;
    logic          stall_clr;

    int n_checks;
    int n_errors;

    pipe_stage_reg #(
        .DATA_W        (DW),
        .ZERO_ON_FLUSH (1'b1),
        .CNT_W         (CW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .stall_cnt (stall_cnt),
        .stall_clr (stall_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int          acc_n;
    int          out_n;
    int          seen_valid;
    logic        took;
    logic [DW-1:0] exp_q[$];

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        stall_clr = 1'b0;

        // ---- reset values
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data",  64'(out_data),  64'd0);
        check("rst_in_ready",  64'(in_ready),  64'd1);
        check("rst_stall_cnt", 64'(stall_cnt), 64'd0);
        reset = 1'b0;

        // ---- streaming, 4 beats, out_ready=1
        in_valid  = 1'b1;
        out_ready = 1'b1;
        in_data   = 32'h0000_00A5;
        #1;
        check("stream_in_ready", 64'(in_ready), 64'd1);
        for (int i = 0; i < 4; i++) begin
            in_data = 32'h0000_00A5 + DW'(i << 8);
            tick();
            check("stream_valid", 64'(out_valid), 64'd1);
            check("stream_data",  64'(out_data),  64'(32'h0000_00A5 + DW'(i << 8)));
            check("stream_cnt",   64'(stall_cnt), 64'd0);
        end
        in_valid = 1'b0;
        tick();
        check("drain_valid", 64'(out_valid), 64'd0);

        // ---- back-pressure: out_ready=0 for 4 edges, upstream keeps offering
        acc_n     = 0;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int c = 0; c < 4; c++) begin
            in_data = 32'hE000_0000 + DW'(acc_n);
            #1;
            took = in_ready;
            tick();
            if (took) begin
                exp_q.push_back(32'hE000_0000 + DW'(acc_n));
                acc_n++;
            end
        end
        check("bp_accepted",  64'(acc_n),     64'(CAP));
        check("bp_in_ready",  64'(in_ready),  64'd0);
        check("bp_stall_cnt", 64'(stall_cnt), 64'd3);
        check("bp_out_data",  64'(out_data),  64'hE000_0000);

        // release: beats must emerge in order, none lost
        in_valid  = 1'b0;
        out_ready = 1'b1;
        out_n     = 0;
        for (int c = 0; c < 4; c++) begin
            #1;
            if (out_valid) begin
                if (exp_q.size() > 0) begin
                    check("bp_order", 64'(out_data), 64'(exp_q.pop_front()));
                end else begin
                    check("bp_extra_beat", 64'(out_data), 64'hDEAD);
                end
                out_n++;
            end
            tick();
        end
        check("bp_emitted",   64'(out_n),     64'(CAP));
        check("bp_cnt_hold",  64'(stall_cnt), 64'd3);

        // ---- flush with stage full and a concurrent input
        in_valid  = 1'b1;
        out_ready = 1'b0;
        in_data   = 32'hF000_0000;
        tick();
        in_data   = 32'hF000_0001;
        tick();
        flush     = 1'b1;
        out_ready = 1'b1;
        in_data   = 32'hF000_0002;
        #1;
        check("fl_in_ready", 64'(in_ready), SKID ? 64'd0 : 64'd1);
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("fl_out_valid", 64'(out_valid), 64'd0);
        check("fl_out_data",  64'(out_data),  64'd0);
        check("fl_in_ready2", 64'(in_ready),  64'd1);
        check("fl_cnt_kept",  64'(stall_cnt), 64'd4);
        seen_valid = 0;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (out_valid) seen_valid++;
        end
        check("fl_no_ghost", 64'(seen_valid), 64'd0);

        // ---- counter saturation: 2^CW+5 stall cycles
        in_valid  = 1'b1;
        out_ready = 1'b0;
        in_data   = 32'h6000_0000;
        tick();
        in_valid  = 1'b0;
        repeat (11) tick();
        check("sat_reach", 64'(stall_cnt), 64'hF);
        repeat (10) tick();
        check("sat_hold",  64'(stall_cnt), 64'hF);
        stall_clr = 1'b1;
        tick();
        check("clr_zero",  64'(stall_cnt), 64'd0);
        stall_clr = 1'b0;
        tick();
        check("clr_recount", 64'(stall_cnt), 64'd1);

        // ---- asynchronous reset with instructions held
        in_valid = 1'b1;
        in_data  = 32'h6000_0001;
        tick();
        in_valid = 1'b0;
        check("pre_rst_in_ready", 64'(in_ready),  64'd0);
        check("pre_rst_valid",    64'(out_valid), 64'd1);
        #3;
        reset = 1'b1;
        #1;
        check("arst_out_valid", 64'(out_valid), 64'd0);
        check("arst_in_ready",  64'(in_ready),  64'd1);
        check("arst_out_data",  64'(out_data),  64'd0);
        check("arst_stall_cnt", 64'(stall_cnt), 64'd0);
        #1;
        reset     = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        in_data   = 32'h7000_0000;
        tick();
        in_valid  = 1'b0;
        check("post_rst_valid", 64'(out_valid), 64'd1);
        check("post_rst_data",  64'(out_data),  64'h7000_0000);
        tick();
        check("post_rst_empty", 64'(out_valid), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
